// File: rtl/rename_stage_if.sv
// rtl/rename_stage_if.sv - decode, free-list, CDB, recovery and dispatch signals of the rename stage
// The slave modport is the rename stage's view of the bus; master is the surrounding pipeline's view.
interface rename_stage_if #(
  parameter int ARCH_REGS     = 32,
  parameter int PHYS_REGS     = 64,
  parameter int PAYLOAD_WIDTH = 32
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int PW = $clog2(PHYS_REGS);

  logic                     dec_valid;
  logic                     dec_ready;
  logic [AW-1:0]            dec_rs1;
  logic [AW-1:0]            dec_rs2;
  logic [AW-1:0]            dec_rd;
  logic                     dec_rd_we;
  logic [PAYLOAD_WIDTH-1:0] dec_payload;

  logic [PW-1:0]            fl_rdata;
  logic                     fl_empty;
  logic                     fl_dequeue;

  logic                     cdb_valid;
  logic [PW-1:0]            cdb_pd;

  logic                     flush;
  logic [ARCH_REGS*PW-1:0]  rrat_map;

  logic                     ren_valid;
  logic                     ren_ready;
  logic [PW-1:0]            ren_ps1;
  logic [PW-1:0]            ren_ps2;
  logic                     ren_ps1_rdy;
  logic                     ren_ps2_rdy;
  logic [PW-1:0]            ren_pd;
  logic [PW-1:0]            ren_pd_old;
  logic [AW-1:0]            ren_rd;
  logic                     ren_rd_we;
  logic [PAYLOAD_WIDTH-1:0] ren_payload;

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_we, dec_payload,
    input  fl_rdata, fl_empty, cdb_valid, cdb_pd, flush, rrat_map, ren_ready,
    output dec_ready, fl_dequeue,
    output ren_valid, ren_ps1, ren_ps2, ren_ps1_rdy, ren_ps2_rdy,
    output ren_pd, ren_pd_old, ren_rd, ren_rd_we, ren_payload
  );

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_we, dec_payload,
    output fl_rdata, fl_empty, cdb_valid, cdb_pd, flush, rrat_map, ren_ready,
    input  dec_ready, fl_dequeue,
    input  ren_valid, ren_ps1, ren_ps2, ren_ps1_rdy, ren_ps2_rdy,
    input  ren_pd, ren_pd_old, ren_rd, ren_rd_we, ren_payload
  );
endinterface

// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - register rename: speculative RAT, physical ready table, registered output to dispatch
// Flush restores the RAT from the retirement image and marks every physical register ready.
module rename_stage #(
  parameter int ARCH_REGS     = 32,
  parameter int PHYS_REGS     = 64,
  parameter int PAYLOAD_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  rename_stage_if.slave  bus
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int PW = $clog2(PHYS_REGS);

  logic [ARCH_REGS-1:0][PW-1:0] rat_q, rat_d;
  logic [PHYS_REGS-1:0]         rdy_q, rdy_d;

  logic                     valid_q, valid_d;
  logic [PW-1:0]            ps1_q, ps1_d;
  logic [PW-1:0]            ps2_q, ps2_d;
  logic                     ps1_rdy_q, ps1_rdy_d;
  logic                     ps2_rdy_q, ps2_rdy_d;
  logic [PW-1:0]            pd_q, pd_d;
  logic [PW-1:0]            pd_old_q, pd_old_d;
  logic [AW-1:0]            rd_q, rd_d;
  logic                     rd_we_q, rd_we_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;

  logic          alloc;
  logic          out_free;
  logic          dec_ready;
  logic          fire;
  logic [PW-1:0] src1, src2;
  logic          src1_rdy, src2_rdy;

  // x0 is hard-wired, so writes to it never consume a physical tag
  assign alloc     = bus.dec_rd_we && (bus.dec_rd != '0);
  assign out_free  = !valid_q || bus.ren_ready;
  assign dec_ready = !bus.flush && out_free && (!alloc || !bus.fl_empty);
  assign fire      = bus.dec_valid && dec_ready && !rst;

  // Sources read the pre-update RAT; the CDB bypass catches a same-cycle writeback
  assign src1     = rat_q[bus.dec_rs1];
  assign src2     = rat_q[bus.dec_rs2];
  assign src1_rdy = rdy_q[src1] || (bus.cdb_valid && (bus.cdb_pd == src1));
  assign src2_rdy = rdy_q[src2] || (bus.cdb_valid && (bus.cdb_pd == src2));

  always_comb begin
    rat_d     = rat_q;
    rdy_d     = rdy_q;
    valid_d   = valid_q;
    ps1_d     = ps1_q;
    ps2_d     = ps2_q;
    ps1_rdy_d = ps1_rdy_q;
    ps2_rdy_d = ps2_rdy_q;
    pd_d      = pd_q;
    pd_old_d  = pd_old_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    payload_d = payload_q;
    if (bus.flush) begin
      rat_d    = bus.rrat_map;
      rat_d[0] = '0;
      rdy_d    = '1;
      valid_d  = 1'b0;
    end else begin
      if (bus.cdb_valid && (bus.cdb_pd != '0)) begin
        rdy_d[bus.cdb_pd] = 1'b1;
      end
      if (fire && alloc) begin
        rat_d[bus.dec_rd] = bus.fl_rdata;
        if (bus.fl_rdata != '0) begin
          rdy_d[bus.fl_rdata] = 1'b0;
        end
      end
      if (out_free) begin
        valid_d = fire;
        if (fire) begin
          ps1_d     = src1;
          ps2_d     = src2;
          ps1_rdy_d = src1_rdy;
          ps2_rdy_d = src2_rdy;
          pd_d      = alloc ? bus.fl_rdata : '0;
          pd_old_d  = rat_q[bus.dec_rd];
          rd_d      = bus.dec_rd;
          rd_we_d   = alloc;
          payload_d = bus.dec_payload;
        end
      end else if (bus.cdb_valid) begin
        // Held instruction: wake its sources so dispatch sees current readiness
        if (bus.cdb_pd == ps1_q) ps1_rdy_d = 1'b1;
        if (bus.cdb_pd == ps2_q) ps2_rdy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= PW'(i);
      end
      rdy_q     <= {{(PHYS_REGS-ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};
      valid_q   <= 1'b0;
      ps1_q     <= '0;
      ps2_q     <= '0;
      ps1_rdy_q <= 1'b0;
      ps2_rdy_q <= 1'b0;
      pd_q      <= '0;
      pd_old_q  <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      rat_q     <= rat_d;
      rdy_q     <= rdy_d;
      valid_q   <= valid_d;
      ps1_q     <= ps1_d;
      ps2_q     <= ps2_d;
      ps1_rdy_q <= ps1_rdy_d;
      ps2_rdy_q <= ps2_rdy_d;
      pd_q      <= pd_d;
      pd_old_q  <= pd_old_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      payload_q <= payload_d;
    end
  end

  assign bus.dec_ready   = dec_ready;
  assign bus.fl_dequeue  = fire && alloc;
  assign bus.ren_valid   = valid_q;
  assign bus.ren_ps1     = ps1_q;
  assign bus.ren_ps2     = ps2_q;
  assign bus.ren_ps1_rdy = ps1_rdy_q;
  assign bus.ren_ps2_rdy = ps2_rdy_q;
  assign bus.ren_pd      = pd_q;
  assign bus.ren_pd_old  = pd_old_q;
  assign bus.ren_rd      = rd_q;
  assign bus.ren_rd_we   = rd_we_q;
  assign bus.ren_payload = payload_q;
endmodule

// File: tb/tb_rename_stage.sv
// tb/tb_rename_stage.sv - directed vectors for rename_stage with hand-computed expectations
module tb_rename_stage;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  rename_stage_if bus ();

  rename_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic [5:0] fl);
    bus.dec_valid   = v;
    bus.dec_rs1     = rs1;
    bus.dec_rs2     = rs2;
    bus.dec_rd      = rd;
    bus.dec_rd_we   = we;
    bus.fl_rdata    = fl;
    bus.dec_payload = {16'hA5A5, 3'b0, rd, 3'b0, rs1, 1'b0, we};
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.ren_ready = 1'b1;
    bus.fl_empty  = 1'b0;
    bus.cdb_valid = 1'b0;
    bus.cdb_pd    = '0;
    bus.flush     = 1'b0;
    for (int i = 0; i < 32; i++) bus.rrat_map[6*i +: 6] = 6'(i);
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 6'd32);
    check("rst_fl_dequeue", 32'(bus.fl_dequeue), 32'd0);
    tick();
    tick();
    check("rst_ren_valid", 32'(bus.ren_valid), 32'd0);
    check("rst_ren_pd", 32'(bus.ren_pd), 32'd0);
    check("rst_ren_pd_old", 32'(bus.ren_pd_old), 32'd0);
    rst = 1'b0;

    // x3 -> p32
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 6'd32);
    check("t1_dec_ready", 32'(bus.dec_ready), 32'd1);
    check("t1_fl_dequeue", 32'(bus.fl_dequeue), 32'd1);
    tick();
    check("t1_valid", 32'(bus.ren_valid), 32'd1);
    check("t1_ps1", 32'(bus.ren_ps1), 32'd1);
    check("t1_ps2", 32'(bus.ren_ps2), 32'd2);
    check("t1_ps1_rdy", 32'(bus.ren_ps1_rdy), 32'd1);
    check("t1_ps2_rdy", 32'(bus.ren_ps2_rdy), 32'd1);
    check("t1_pd", 32'(bus.ren_pd), 32'd32);
    check("t1_pd_old", 32'(bus.ren_pd_old), 32'd3);
    check("t1_rd", 32'(bus.ren_rd), 32'd3);
    check("t1_rd_we", 32'(bus.ren_rd_we), 32'd1);
    check("t1_payload", bus.ren_payload, {16'hA5A5, 3'b0, 5'd3, 3'b0, 5'd1, 1'b0, 1'b1});

    // back-to-back dependent: x3 -> p33, source x3 sees p32
    issue(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 6'd33);
    check("t2_fl_dequeue", 32'(bus.fl_dequeue), 32'd1);
    tick();
    check("t2_ps1", 32'(bus.ren_ps1), 32'd32);
    check("t2_ps1_rdy", 32'(bus.ren_ps1_rdy), 32'd0);
    check("t2_ps2", 32'(bus.ren_ps2), 32'd0);
    check("t2_ps2_rdy", 32'(bus.ren_ps2_rdy), 32'd1);
    check("t2_pd_old", 32'(bus.ren_pd_old), 32'd32);
    check("t2_pd", 32'(bus.ren_pd), 32'd33);

    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0);
    check("idle_fl_dequeue", 32'(bus.fl_dequeue), 32'd0);
    tick();
    check("idle_valid", 32'(bus.ren_valid), 32'd0);

    // same-cycle CDB bypass on p33; x5 -> p34
    issue(1'b1, 5'd3, 5'd0, 5'd5, 1'b1, 6'd34);
    bus.cdb_valid = 1'b1;
    bus.cdb_pd    = 6'd33;
    tick();
    bus.cdb_valid = 1'b0;
    check("byp_ps1", 32'(bus.ren_ps1), 32'd33);
    check("byp_ps1_rdy", 32'(bus.ren_ps1_rdy), 32'd1);
    check("byp_pd_old", 32'(bus.ren_pd_old), 32'd5);
    check("byp_pd", 32'(bus.ren_pd), 32'd34);

    // non-allocating instruction reading x5 (p34, not ready), then hold it
    issue(1'b1, 5'd1, 5'd5, 5'd7, 1'b0, 6'd40);
    check("na_fl_dequeue", 32'(bus.fl_dequeue), 32'd0);
    tick();
    check("na_ps2", 32'(bus.ren_ps2), 32'd34);
    check("na_ps2_rdy", 32'(bus.ren_ps2_rdy), 32'd0);
    check("na_pd", 32'(bus.ren_pd), 32'd0);
    check("na_rd_we", 32'(bus.ren_rd_we), 32'd0);
    check("na_pd_old", 32'(bus.ren_pd_old), 32'd7);
    bus.ren_ready = 1'b0;
    issue(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 6'd35);
    check("bp_dec_ready", 32'(bus.dec_ready), 32'd0);
    check("bp_fl_dequeue", 32'(bus.fl_dequeue), 32'd0);
    tick();
    check("bp_valid", 32'(bus.ren_valid), 32'd1);
    check("bp_ps2_rdy", 32'(bus.ren_ps2_rdy), 32'd0);
    check("bp_pd_old", 32'(bus.ren_pd_old), 32'd7);
    bus.cdb_valid = 1'b1;
    bus.cdb_pd    = 6'd34;
    tick();
    bus.cdb_valid = 1'b0;
    check("wk_ps2_rdy", 32'(bus.ren_ps2_rdy), 32'd1);
    check("wk_ps2", 32'(bus.ren_ps2), 32'd34);
    check("wk_ps1_rdy", 32'(bus.ren_ps1_rdy), 32'd1);
    check("wk_pd_old", 32'(bus.ren_pd_old), 32'd7);
    check("wk_valid", 32'(bus.ren_valid), 32'd1);

    // empty free list
    bus.ren_ready = 1'b1;
    bus.fl_empty  = 1'b1;
    issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 6'd36);
    check("em_dec_ready", 32'(bus.dec_ready), 32'd0);
    check("em_fl_dequeue", 32'(bus.fl_dequeue), 32'd0);
    tick();
    check("em_valid", 32'(bus.ren_valid), 32'd0);
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 6'd36);
    check("x0_dec_ready", 32'(bus.dec_ready), 32'd1);
    check("x0_fl_dequeue", 32'(bus.fl_dequeue), 32'd0);
    tick();
    check("x0_valid", 32'(bus.ren_valid), 32'd1);
    check("x0_pd", 32'(bus.ren_pd), 32'd0);
    check("x0_rd_we", 32'(bus.ren_rd_we), 32'd0);
    check("x0_ps1", 32'(bus.ren_ps1), 32'd0);
    check("x0_ps1_rdy", 32'(bus.ren_ps1_rdy), 32'd1);
    check("x0_pd_old", 32'(bus.ren_pd_old), 32'd0);
    issue(1'b1, 5'd0, 5'd3, 5'd5, 1'b0, 6'd36);
    check("we0_dec_ready", 32'(bus.dec_ready), 32'd1);
    tick();
    check("we0_pd", 32'(bus.ren_pd), 32'd0);
    check("we0_pd_old", 32'(bus.ren_pd_old), 32'd34);
    check("we0_ps1", 32'(bus.ren_ps1), 32'd0);
    check("we0_ps2", 32'(bus.ren_ps2), 32'd33);
    bus.fl_empty = 1'b0;

    // x4 -> p36, then flush to the identity image while ren_valid is high
    issue(1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 6'd36);
    tick();
    check("pf_valid", 32'(bus.ren_valid), 32'd1);
    check("pf_pd", 32'(bus.ren_pd), 32'd36);
    bus.flush = 1'b1;
    issue(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 6'd37);
    check("fl_dec_ready", 32'(bus.dec_ready), 32'd0);
    check("fl_fl_dequeue", 32'(bus.fl_dequeue), 32'd0);
    tick();
    bus.flush = 1'b0;
    check("fl_valid", 32'(bus.ren_valid), 32'd0);
    issue(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 6'd0);
    tick();
    check("af_ps1", 32'(bus.ren_ps1), 32'd3);
    check("af_ps2", 32'(bus.ren_ps2), 32'd4);
    check("af_ps1_rdy", 32'(bus.ren_ps1_rdy), 32'd1);
    check("af_ps2_rdy", 32'(bus.ren_ps2_rdy), 32'd1);

    // reset mid-operation: x3 -> p40 then reset restores identity and readiness
    issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 6'd40);
    tick();
    check("mr_pre_pd", 32'(bus.ren_pd), 32'd40);
    rst = 1'b1;
    bus.flush = 1'b1;
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0);
    tick();
    rst = 1'b0;
    bus.flush = 1'b0;
    check("mr_valid", 32'(bus.ren_valid), 32'd0);
    check("mr_pd", 32'(bus.ren_pd), 32'd0);
    issue(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 6'd0);
    tick();
    check("mr_ps1", 32'(bus.ren_ps1), 32'd3);
    check("mr_ps1_rdy", 32'(bus.ren_ps1_rdy), 32'd1);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage between decode and dispatch. Consumes physical register tags from the physical-register free list.
- Holds the speculative register alias table (RAT) and a per-physical-register ready table.
- Emits one renamed instruction per cycle through a registered valid/ready output to dispatch/ROB.
- On flush, restores the RAT from the retirement RAT image.

Parameters:
ARCH_REGS, 32, number of architectural registers; the index width is clog2 of this (5).
PHYS_REGS, 64, number of physical registers; the tag width is clog2 of this (6).
PAYLOAD_WIDTH, 32, opaque decode payload carried alongside the instruction (instruction bits).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dec_valid  in  1  decode holds an instruction
dec_ready  out  1  rename accepts this cycle
dec_rs1, dec_rs2  in  5 each  architectural source registers
dec_rd  in  5  architectural destination register
dec_rd_we  in  1  instruction writes rd
dec_payload  in  PAYLOAD_WIDTH  passthrough
fl_rdata  in  6  free-list head tag, valid the same cycle fl_dequeue is high
fl_empty  in  1  free list empty
fl_dequeue  out  1  pop the free-list head
cdb_valid  in  1  writeback broadcast
cdb_pd  in  6  tag written back
flush  in  1  mispredict/exception recovery
rrat_map  in  32*6  retirement RAT; arch reg i occupies bits [6i+5:6i]
ren_valid  out  1  output register holds an instruction
ren_ready  in  1  dispatch accepts
ren_ps1, ren_ps2  out  6 each  source tags
ren_ps1_rdy, ren_ps2_rdy  out  1 each  source value already produced
ren_pd  out  6  new destination tag (0 if no allocation)
ren_pd_old  out  6  previous mapping of rd, freed by the ROB at commit
ren_rd  out  5  architectural rd
ren_rd_we  out  1  allocation flag
ren_payload  out  PAYLOAD_WIDTH  passthrough

Behaviour:
- Reset:
  - RAT[i] = i.
  - ready[p] = 1 for p 0..31 and 0 for p 32..63.
  - ren_valid = 0; all other ren_* outputs = 0.
  - fl_dequeue = 0 during reset.
- alloc = dec_rd_we && (dec_rd != 0). x0 is never renamed, RAT[0] is fixed at 0, and ready[0] is fixed at 1.
- Acceptance:
  - dec_ready = !flush && (!ren_valid || ren_ready) && (!alloc || !fl_empty). This is combinational on dec_rd and dec_rd_we.
  - fire = dec_valid && dec_ready.
  - fl_dequeue = fire && alloc. fl_rdata is sampled in that same cycle.
- On fire, the output register loads the following:
  - ren_ps1 = RAT[rs1] and ren_ps2 = RAT[rs2], read before this cycle's RAT update. When rs1 == rd, the source gets the old mapping.
  - ren_psX_rdy = ready[psX] || (cdb_valid && cdb_pd == psX). This CDB bypass covers a same-cycle broadcast.
  - ren_pd_old = RAT[rd]. ren_pd = fl_rdata when alloc, else 0. ren_rd_we = alloc.
  - On the same edge, when alloc: RAT[rd] <= fl_rdata and ready[fl_rdata] <= 0.
- Output register:
  - ren_valid <= fire if (!ren_valid || ren_ready); otherwise it holds.
  - Latency is 1 cycle from fire to ren_valid.
  - Back-to-back fires are permitted, and a dependent younger instruction sees the RAT updated by the older one.
- Held-output wakeup: while ren_valid && !ren_ready, a cdb_valid whose cdb_pd matches ren_ps1 or ren_ps2 sets the corresponding _rdy bit.
- CDB: when cdb_valid and cdb_pd != 0, ready[cdb_pd] <= 1. A same-cycle allocation and CDB cannot target the same tag, because an allocated tag is free.
- Free list empty with alloc: dec_ready = 0 and the stage stalls with no dequeue. Non-allocating instructions still proceed.
- Flush (highest priority, single cycle):
  - RAT <= rrat_map and all ready bits <= 1.
  - ren_valid <= 0.
  - No fire and no fl_dequeue that cycle; CDB is ignored.
  - The next cycle resumes normally.
- Reset asserted mid-operation overrides flush and returns every state to its reset value.

Test Plan:
- Reset, then dec rs1=1, rs2=2, rd=3, we=1, fl_rdata=32 -> next cycle ren_ps1=1, ren_ps2=2, both rdy=1, ren_pd=32, ren_pd_old=3, fl_dequeue pulsed 1 cycle; RAT[3]=32.
- Back-to-back: (rd=3 ← fl 32), then (rs1=3, rd=3 ← fl 33) -> second ren_ps1=32, ren_ps1_rdy=0, ren_pd_old=32, ren_pd=33.
- CDB bypass and wakeup: consumer of p32 fires in the same cycle as cdb_pd=32 -> ren_ps1_rdy=1. Hold ren_ready=0 with ps2=33 not ready, then broadcast cdb_pd=33 -> ren_ps2_rdy rises while held; outputs are otherwise stable.
- Backpressure and empty list:
  - ren_ready=0 with ren_valid=1 -> dec_ready=0, no fl_dequeue.
  - fl_empty=1 with rd=5 -> stall.
  - fl_empty=1 with rd=0, or with we=0 -> fires, ren_pd=0, ren_rd_we=0.
- x0: rd=0, we=1 -> no dequeue, RAT[0] stays 0. rs1=0 -> ps1=0, rdy=1.
- Flush: after renaming x3→32, x4→33, assert flush with rrat_map identity while ren_valid=1 -> next cycle ren_valid=0, RAT[3]=3, RAT[4]=4, no dequeue in the flush cycle; the following rs1=3 gives ps1=3, rdy=1.
